sysbus_arbiter: RTL
===================

// Module: sysbus_arbiter
// PURPOSE
//  Shares one Sysbus master port between two requesters: instruction fetch (port f) and data memory (port d).
//  Grants whole transactions with round-robin priority and locks the bus to the owner until completion.
//  Routes request, ack, write-data and response beats between the owner and the bus.
//  Sits between the core's fetch/data units and the top-level Sysbus.
// PARAMETERS
//  DATA_WIDTH  64  width of req/resp payload
//  TAG_WIDTH   13  width of reqtag/resptag; MSB is the read/write bit (1=READ, 0=WRITE)
//  BEATS       8   data beats per transaction (64-byte line / 8 bytes)
// PORTS
//  clk          in   1           clock, all state updates on posedge
//  reset        in   1           synchronous, active-high
//  f_reqcyc     in   1           fetch request valid; held until f_reqack
//  f_req        in   DATA_WIDTH  fetch address / write data
//  f_reqtag     in   TAG_WIDTH   fetch request tag
//  f_reqack     out  1           fetch request/beat accepted
//  f_respcyc    out  1           fetch response beat valid
//  f_resp       out  DATA_WIDTH  fetch response data
//  f_resptag    out  TAG_WIDTH   fetch response tag
//  f_respack    in   1           fetch accepts response beat
//  d_*          -    -           same eight signals for the data port
//  bus_reqcyc   out  1           Sysbus request valid
//  bus_req      out  DATA_WIDTH  Sysbus request payload
//  bus_reqtag   out  TAG_WIDTH   Sysbus request tag
//  bus_reqack   in   1           Sysbus request/beat accepted
//  bus_respcyc  in   1           Sysbus response beat valid
//  bus_resp     in   DATA_WIDTH  Sysbus response data
//  bus_resptag  in   TAG_WIDTH   Sysbus response tag
//  bus_respack  out  1           response beat accepted
//  owner        out  1           0=fetch, 1=data; meaningful when busy=1
//  busy         out  1           state != IDLE
// BEHAVIOUR
//  State machine:
//  - States: IDLE, REQ, WDATA, RESP.
//  - Registered: state, owner, beat counter (clog2(BEATS)+1 bits), prio_d (1 means data wins a tie).
//  - Reset: state=IDLE, owner=0, count=0, prio_d=0 (fetch wins the first tie).
//    Every output is 0 during reset and in IDLE, and bus_resp* do not reach either port.
//  - Reset mid-transaction: abandon the transaction and go to IDLE next cycle. No drain.
//  Transitions:
//  - IDLE: if only one port has reqcyc, grant it. If both do, grant d when prio_d=1, else f.
//    Then owner<=grant, state<=REQ. No bus activity in IDLE (1-cycle grant latency).
//  - REQ: bus_reqcyc/req/reqtag = owner's inputs (combinational mux). Owner's reqack = bus_reqack, same cycle.
//    Non-owner reqack=0.
//    On bus_reqack with tag MSB=1 (read): go to RESP, count=0.
//    On bus_reqack with tag MSB=0 (write): go to WDATA, count=0.
//    If the owner drops reqcyc before ack (protocol abort): go to IDLE; prio_d unchanged.
//  - WDATA: forward owner's reqcyc/req/reqtag and bus_reqack as in REQ.
//    A beat is counted on reqcyc&&reqack.
//    When the BEATS-th beat is accepted: go to IDLE, prio_d <= ~owner.
//  - RESP: owner's respcyc/resp/resptag = bus_*. bus_respack = owner's respack. Non-owner respcyc=0.
//    A beat is counted on bus_respcyc&&bus_respack.
//    When the BEATS-th beat is accepted: go to IDLE, prio_d <= ~owner.
//  Boundary conditions:
//  - bus_respcyc outside RESP: bus_respack=0, nothing forwarded (immediate assertion fires in simulation).
//  - bus_reqack outside REQ/WDATA: ignored (assertion fires).
//  - Beat counter never wraps: it saturates at BEATS and the state exits in the same cycle.
//  - Requests arriving during a transaction wait. A request present when the state returns to IDLE
//    is granted in that IDLE cycle, so the bus is idle for 1 cycle minimum between transactions.
//  - Round-robin is strict alternation only under contention; a lone requester may win repeatedly.
// TESTING
//  - Reset then f read (tag MSB=1, addr 0x1000), ack at cycle 3, 8 resp beats 0..7
//    -> f gets 8 beats in order, d_respcyc=0 throughout, busy falls after beat 8.
//  - f and d both assert reqcyc in the same cycle after reset -> f granted first;
//    d's request reaches the bus 1 cycle after f's 8th beat.
//  - d write (tag MSB=0): address acked, then 8 data beats with bus_reqack stalled on beats 2 and 5
//    -> exactly 8 acks to d, state back to IDLE, no response routed.
//  - Continuous contention for 4 transactions -> grant order f,d,f,d.
//  - Reset asserted during RESP beat 4 -> next cycle busy=0, all outputs 0;
//    a new f request is granted normally afterwards.
//  - Spurious bus_respcyc in IDLE -> bus_respack=0, f/d_respcyc=0, assertion reported.

Source files
------------

// File: rtl/sysbus_arbiter.sv
// Two-port Sysbus arbiter: fetch (f) and data (d) share one bus master.
// Ports: clk/reset, f_* and d_* requester ports, bus_* master port, owner/busy status.
module sysbus_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 13,
  parameter int BEATS      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  f_reqcyc,
  input  logic [DATA_WIDTH-1:0] f_req,
  input  logic [TAG_WIDTH-1:0]  f_reqtag,
  output logic                  f_reqack,
  output logic                  f_respcyc,
  output logic [DATA_WIDTH-1:0] f_resp,
  output logic [TAG_WIDTH-1:0]  f_resptag,
  input  logic                  f_respack,
  input  logic                  d_reqcyc,
  input  logic [DATA_WIDTH-1:0] d_req,
  input  logic [TAG_WIDTH-1:0]  d_reqtag,
  output logic                  d_reqack,
  output logic                  d_respcyc,
  output logic [DATA_WIDTH-1:0] d_resp,
  output logic [TAG_WIDTH-1:0]  d_resptag,
  input  logic                  d_respack,
  output logic                  bus_reqcyc,
  output logic [DATA_WIDTH-1:0] bus_req,
  output logic [TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                  bus_reqack,
  input  logic                  bus_respcyc,
  input  logic [DATA_WIDTH-1:0] bus_resp,
  input  logic [TAG_WIDTH-1:0]  bus_resptag,
  output logic                  bus_respack,
  output logic                  owner,
  output logic                  busy
);

  localparam int CW = $clog2(BEATS) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WDATA,
    S_RESP
  } state_t;

  state_t          r_state;
  logic            r_owner;
  logic            r_prio_d;
  logic [CW-1:0]   r_count;

  logic                  w_own_reqcyc;
  logic [DATA_WIDTH-1:0] w_own_req;
  logic [TAG_WIDTH-1:0]  w_own_reqtag;
  logic                  w_own_respack;
  logic                  w_grant;
  logic                  w_busy;
  logic                  w_req_ph;
  logic                  w_resp_ph;
  logic                  w_last;

  assign w_own_reqcyc  = r_owner ? d_reqcyc  : f_reqcyc;
  assign w_own_req     = r_owner ? d_req     : f_req;
  assign w_own_reqtag  = r_owner ? d_reqtag  : f_reqtag;
  assign w_own_respack = r_owner ? d_respack : f_respack;

  // A lone requester wins outright; a tie goes to whoever prio_d favours.
  assign w_grant = (f_reqcyc && d_reqcyc) ? r_prio_d : d_reqcyc;

  // Outputs are forced quiet while reset is held, even before the edge.
  assign w_busy    = !reset && (r_state != S_IDLE);
  assign w_req_ph  = !reset && (r_state == S_REQ || r_state == S_WDATA);
  assign w_resp_ph = !reset && (r_state == S_RESP);
  assign w_last    = (r_count == CW'(BEATS - 1));

  assign bus_reqcyc  = w_req_ph && w_own_reqcyc;
  assign bus_req     = w_req_ph ? w_own_req : '0;
  assign bus_reqtag  = w_req_ph ? w_own_reqtag : '0;
  assign f_reqack    = w_req_ph && !r_owner && bus_reqack;
  assign d_reqack    = w_req_ph && r_owner && bus_reqack;

  assign bus_respack = w_resp_ph && w_own_respack;
  assign f_respcyc   = w_resp_ph && !r_owner && bus_respcyc;
  assign f_resp      = (w_resp_ph && !r_owner) ? bus_resp : '0;
  assign f_resptag   = (w_resp_ph && !r_owner) ? bus_resptag : '0;
  assign d_respcyc   = w_resp_ph && r_owner && bus_respcyc;
  assign d_resp      = (w_resp_ph && r_owner) ? bus_resp : '0;
  assign d_resptag   = (w_resp_ph && r_owner) ? bus_resptag : '0;

  assign owner = w_busy && r_owner;
  assign busy  = w_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_owner  <= 1'b0;
      r_count  <= '0;
      r_prio_d <= 1'b0;
    end else begin
      assert (!(bus_respcyc && r_state != S_RESP))
        else $warning("sysbus_arbiter: bus_respcyc outside RESP");
      assert (!(bus_reqack && r_state != S_REQ && r_state != S_WDATA))
        else $warning("sysbus_arbiter: bus_reqack outside REQ/WDATA");
      unique case (r_state)
        S_IDLE: begin
          if (f_reqcyc || d_reqcyc) begin
            r_owner <= w_grant;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (w_own_reqcyc && bus_reqack) begin
            r_count <= '0;
            r_state <= w_own_reqtag[TAG_WIDTH-1] ? S_RESP : S_WDATA;
          end else if (!w_own_reqcyc) begin
            r_state <= S_IDLE;
          end
        end
        S_WDATA: begin
          if (w_own_reqcyc && bus_reqack) begin
            r_count <= r_count + CW'(1);
            if (w_last) begin
              r_state  <= S_IDLE;
              r_prio_d <= ~r_owner;
            end
          end
        end
        S_RESP: begin
          if (bus_respcyc && w_own_respack) begin
            r_count <= r_count + CW'(1);
            if (w_last) begin
              r_state  <= S_IDLE;
              r_prio_d <= ~r_owner;
            end
          end
        end
      endcase
    end
  end

endmodule
